// File: rtl/bits_pkg.sv
// Shared widths and helpers for the bit packer and its output FIFO.
package bits_pkg;

    localparam int WORD_W  = 32;
    localparam int FIELD_W = 15;
    localparam int LEN_W   = 4;
    localparam int ACC_W   = 47;
    localparam int CNT_W   = 6;
    localparam int ENTRY_W = WORD_W + 1;

    // Mask with the low 'len' bits set; len=0 gives an all-zero mask.
    function automatic logic [FIELD_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [FIELD_W:0] one_hot;
        one_hot = {{FIELD_W{1'b0}}, 1'b1} << len;
        return one_hot[FIELD_W-1:0] - {{(FIELD_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/bits_wfifo.sv
// Small synchronous FIFO holding {last, word} entries for the packer output.
module bits_wfifo
    import bits_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               rd,
    output logic [ENTRY_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wp;
    logic [AW-1:0]      rp;
    logic [AW:0]        count;
    logic               do_wr;
    logic               do_rd;

    // A write into a full FIFO is accepted only when the head leaves at the same edge.
    always_comb begin
        full  = (count == (AW+1)'(DEPTH));
        empty = (count == '0);
        do_rd = rd && !empty;
        do_wr = wr && (!full || do_rd);
        rdata = mem[rp];
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wp] <= wdata;
    end

    // Pointers wrap naturally at DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/bits_pack.sv
// Repacks 0..15-bit fields LSB-first into 32-bit words, buffers them and
// delivers them under stop-style backpressure; flags dropped words.
module bits_pack
    import bits_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pushin,
    input  logic [LEN_W-1:0]   lenin,
    input  logic [FIELD_W-1:0] datain,
    input  logic               flushin,
    input  logic               stopin,
    output logic               pushout,
    output logic [WORD_W-1:0]  dataout,
    output logic               lastout,
    output logic               overflow
);

    logic [ACC_W-1:0]   acc, acc_p, acc_n, base_acc;
    logic [CNT_W-1:0]   cnt, cnt_p, cnt_n, base_cnt;
    logic               flush_pend, pend_n;
    logic [FIELD_W-1:0] m;
    logic               wr;
    logic [ENTRY_W-1:0] wdata;
    logic               fifo_rd;
    logic [ENTRY_W-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;

    // Next accumulator state and the (at most one) word written this edge.
    // A pending flush empties the accumulator first, so the same-cycle push
    // lands in a clean accumulator and cannot complete a word.
    always_comb begin
        m        = datain & len_mask(lenin);
        base_acc = flush_pend ? '0 : acc;
        base_cnt = flush_pend ? '0 : cnt;
        acc_p    = base_acc;
        cnt_p    = base_cnt;
        if (pushin) begin
            acc_p = base_acc | (ACC_W'(m) << base_cnt);
            cnt_p = base_cnt + CNT_W'(lenin);
        end
        acc_n  = acc_p;
        cnt_n  = cnt_p;
        pend_n = 1'b0;
        wr     = 1'b0;
        wdata  = '0;
        if (flush_pend) begin
            wr    = 1'b1;
            wdata = {1'b1, acc[WORD_W-1:0]};
        end else if (cnt_p >= CNT_W'(WORD_W)) begin
            wr     = 1'b1;
            wdata  = {1'b0, acc_p[WORD_W-1:0]};
            acc_n  = acc_p >> WORD_W;
            cnt_n  = cnt_p - CNT_W'(WORD_W);
            pend_n = flushin && (cnt_n != '0);
        end else if (flushin && (cnt_p != '0)) begin
            wr    = 1'b1;
            wdata = {1'b1, acc_p[WORD_W-1:0]};
            acc_n = '0;
            cnt_n = '0;
        end
    end

    // Accumulator, bit count and pending-flush flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            acc        <= acc_n;
            cnt        <= cnt_n;
            flush_pend <= pend_n;
        end
    end

    assign fifo_rd = !fifo_empty && !stopin;

    bits_wfifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_wfifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .wdata (wdata),
        .rd    (fifo_rd),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output register: present the popped head, otherwise hold the last word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pushout <= 1'b0;
            dataout <= '0;
            lastout <= 1'b0;
        end else begin
            pushout <= fifo_rd;
            if (fifo_rd) begin
                dataout <= fifo_rdata[WORD_W-1:0];
                lastout <= fifo_rdata[WORD_W];
            end
        end
    end

    // Sticky drop flag: a word arrived at a full FIFO that did not pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (wr && fifo_full && !fifo_rd) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bits_pack.sv
// Randomised and directed bench for bits_pack with a bit-queue reference model.
module tb_bits_pack;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pushin;
    logic [3:0]  lenin;
    logic [14:0] datain;
    logic        flushin;
    logic        stopin;
    logic        pushout;
    logic [31:0] dataout;
    logic        lastout;
    logic        overflow;

    bits_pack #(.DEPTH(DEPTH), .AW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .pushin   (pushin),
        .lenin    (lenin),
        .datain   (datain),
        .flushin  (flushin),
        .stopin   (stopin),
        .pushout  (pushout),
        .dataout  (dataout),
        .lastout  (lastout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Reference model state: pending bits oldest first, and an abstract FIFO.
    bit          model_q[$];
    bit          model_pend;
    logic [32:0] mfifo[$];
    logic [32:0] exp_q[$];
    bit          exp_pop;
    bit          exp_ovf;

    // Reference model: rules applied to a queue of bits at every rising edge.
    always @(posedge clk or negedge rst) begin
        logic [32:0] w;
        bit          have;
        bit          popped;
        if (!rst) begin
            model_q.delete();
            mfifo.delete();
            model_pend = 1'b0;
            exp_pop    = 1'b0;
            exp_ovf    = 1'b0;
        end else begin
            have = 1'b0;
            w    = '0;
            if (model_pend) begin
                for (int i = 0; i < 32 && model_q.size() > 0; i++) w[i] = model_q.pop_front();
                w[32]      = 1'b1;
                have       = 1'b1;
                model_pend = 1'b0;
                if (pushin) for (int i = 0; i < int'(lenin); i++) model_q.push_back(datain[i]);
            end else begin
                if (pushin) for (int i = 0; i < int'(lenin); i++) model_q.push_back(datain[i]);
                if (model_q.size() >= 32) begin
                    for (int i = 0; i < 32; i++) w[i] = model_q.pop_front();
                    have = 1'b1;
                    if (flushin && model_q.size() > 0) model_pend = 1'b1;
                end else if (flushin && model_q.size() > 0) begin
                    for (int i = 0; i < 32 && model_q.size() > 0; i++) w[i] = model_q.pop_front();
                    w[32] = 1'b1;
                    have  = 1'b1;
                end
            end
            popped = (mfifo.size() > 0) && !stopin;
            if (popped) exp_q.push_back(mfifo.pop_front());
            if (have) begin
                if (mfifo.size() < DEPTH) mfifo.push_back(w);
                else exp_ovf = 1'b1;
            end
            exp_pop = popped;
        end
    end

    int vectors     = 0;
    int miscompares = 0;
    int rd_idx      = 0;
    bit final_req   = 1'b0;
    bit final_done  = 1'b0;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: samples the DUT away from the rising edge and consumes the scoreboard.
    always @(negedge clk or negedge rst) begin
        #1;
        if (!rst) begin
            check("reset_pushout", {32'd0, pushout}, 33'd0);
            check("reset_data", {lastout, dataout}, 33'd0);
            check("reset_overflow", {32'd0, overflow}, 33'd0);
            rd_idx = exp_q.size();
        end else begin
            check("pushout", {32'd0, pushout}, {32'd0, exp_pop});
            if (pushout && exp_pop) begin
                if (rd_idx < exp_q.size()) begin
                    check("word", {lastout, dataout}, exp_q[rd_idx]);
                    rd_idx++;
                end else begin
                    check("scoreboard_empty", 33'd1, 33'd0);
                end
            end
            check("overflow", {32'd0, overflow}, {32'd0, exp_ovf});
            if (final_req && !final_done) begin
                check("drained", 33'(exp_q.size() - rd_idx), 33'd0);
                check("model_fifo_empty", 33'(mfifo.size()), 33'd0);
                final_done = 1'b1;
            end
        end
    end

    task automatic cyc(input bit p, input int l, input int d, input bit f);
        pushin  = p;
        lenin   = l[3:0];
        datain  = d[14:0];
        flushin = f;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 1'b0);
    endtask

    task automatic pulse_reset();
        pushin  = 1'b0;
        flushin = 1'b0;
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b0;
        pushin  = 1'b0;
        lenin   = '0;
        datain  = '0;
        flushin = 1'b0;
        stopin  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(2);

        // eight nibbles -> one word
        for (int i = 1; i <= 8; i++) cyc(1'b1, 4, i, 1'b0);
        idle(6);

        // three full fields, then a flush of the 13-bit remainder
        for (int i = 0; i < 3; i++) cyc(1'b1, 15, 'h7FFF, 1'b0);
        idle(2);
        cyc(1'b0, 0, 0, 1'b1);
        idle(4);

        // masking of datain bits above lenin
        cyc(1'b1, 3, 'h7FF8, 1'b0);
        cyc(1'b1, 15, 'h7FFF, 1'b0);
        cyc(1'b1, 15, 'h7FFF, 1'b0);
        cyc(1'b1, 2, 'h7FFF, 1'b0);
        cyc(1'b0, 0, 0, 1'b1);
        idle(4);

        // flush coinciding with a word completion
        for (int i = 0; i < 7; i++) cyc(1'b1, 4, 1, 1'b0);
        cyc(1'b1, 2, 0, 1'b0);
        cyc(1'b1, 4, 'hF, 1'b1);
        cyc(1'b1, 5, 'h15, 1'b1);
        idle(5);

        // backpressure: five words into a four-deep FIFO
        stopin = 1'b1;
        for (int i = 0; i < 40; i++) cyc(1'b1, 4, i, 1'b0);
        idle(3);
        stopin = 1'b0;
        idle(8);

        // asynchronous reset with a partial word and queued words
        stopin = 1'b1;
        for (int i = 0; i < 21; i++) cyc(1'b1, 4, i + 3, 1'b0);
        pulse_reset();
        stopin = 1'b0;
        cyc(1'b1, 4, 'hA, 1'b0);
        cyc(1'b0, 0, 0, 1'b1);
        idle(5);

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            stopin = ($urandom_range(0, 3) == 0);
            cyc(($urandom_range(0, 4) != 0), int'($urandom_range(0, 15)),
                int'($urandom & 32'h7FFF), ($urandom_range(0, 11) == 0));
            if (i == 1500) pulse_reset();
        end
        stopin = 1'b0;
        cyc(1'b0, 0, 0, 1'b1);
        idle(12);

        final_req = 1'b1;
        for (int i = 0; i < 10 && !final_done; i++) @(negedge clk);
        if (!final_done) $display("FAIL final_check: got not done, required done");
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
